lights_board: RTL
=================

LIGHTS_BOARD -- requirements
Module: lights_board

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Position, input, 6 bits: cursor cell index from the grid counter; row = Position[5:3], col = Position[2:0].
REQ-004 SHALL have port Toggle, input, 1 bit: level press request; acted on at its rising edge only.
REQ-005 SHALL have port Load, input, 1 bit: start a new game from Pattern.
REQ-006 SHALL have port Pattern, input, 64 bits: initial board; bit i is cell i.
REQ-007 SHALL have port Lights, output, 64 bits: current board; bit i = 1 means cell i is on.
REQ-008 SHALL have port Moves, output, 8 bits: count of accepted presses since the last Load.
REQ-009 SHALL have port Won, output, 1 bit: high while in state WON.

Function
REQ-010 SHALL register Toggle into toggle_q each cycle; a press SHALL be detected when Toggle=1 and toggle_q=0.
REQ-011 SHALL implement states IDLE, PLAY and WON.
REQ-012 IDLE: Lights=0 and Moves=0, presses ignored, Load leaves IDLE.
REQ-013 Load=1 in any state SHALL, at that edge, set Lights<=Pattern and Moves<=0; next state SHALL be WON if Pattern==0, else PLAY.
REQ-014 On a detected press in PLAY with Load=0, SHALL XOR at that edge: cell Position, row-1, row+1, col-1 and col+1 in the same row.
REQ-015 Out-of-grid neighbours (row<0, row>7, col<0, col>7) SHALL be omitted.
REQ-016 Col-1 of col 0 SHALL NOT alias to col 7 of the previous row; col+1 of col 7 SHALL NOT alias to col 0 of the next row.
REQ-017 Latency: the updated Lights SHALL be visible the cycle after the press edge.
REQ-018 A press in PLAY SHALL increment Moves at the same edge; Moves SHALL saturate at 255.
REQ-019 If the post-press board is 0, state SHALL become WON at the same edge; Won=1 from the next cycle.
REQ-020 Presses in IDLE or WON SHALL change nothing.
REQ-021 Load and a press on the same edge: Load SHALL take priority and the press SHALL be discarded.
REQ-022 A Toggle held high for N cycles SHALL count as exactly one press.
REQ-023 Position SHALL be sampled only on the press edge.

Reset
REQ-024 reset=1 at a clock edge SHALL set state=IDLE, Lights=0, Moves=0, Won=0 and toggle_q=0, overriding Load and Toggle.
REQ-025 Reset mid-game SHALL discard the board; the next game starts only on Load.
REQ-026 Toggle held high across reset release SHALL count as a press edge only after a 0 has been sampled.

Configuration
REQ-027 Macro TORUS_EN defined SHALL make the neighbour logic wrap: row-1 of row 0 is row 7 and vice versa, and col-1 of col 0 is col 7 of the same row and vice versa.
REQ-028 Without TORUS_EN, REQ-015 and REQ-016 edge clipping SHALL apply.
REQ-029 No other behaviour SHALL depend on TORUS_EN.

Verification
REQ-030 Reset, then Toggle pulses at Position 10 -> Lights=0, Moves=0, Won=0 throughout.
REQ-031 Load Pattern=64'h0000_0000_0000_0001, then press at Position 0 -> Lights=64'h0000_0000_0000_0102, Moves=1, Won=0.
REQ-032 Load Pattern=64'h0000_0008_1C08_0000, then press at Position 27 -> Lights=0, Moves=1, Won=1 next cycle; a further press changes nothing.
REQ-033 In PLAY, hold Toggle high 5 cycles at Position 9, then Load and press on the same edge -> one move counted from the held press; on the shared edge Lights=Pattern and Moves=0.
REQ-034 Load Pattern=64'h0000_0010_0000_0000, press at Position 0 -> Lights=64'h0000_0010_0000_0103 without TORUS_EN and 64'h0100_0010_0000_0183 with TORUS_EN.
REQ-035 Make 256 presses in PLAY without winning -> Moves stays 255; then assert reset mid-game -> all outputs return to 0.

Source files
------------

// File: rtl/lights_board.sv
// lights_board: 8x8 "lights out" game board.
// A rising edge on Toggle presses the cell at Position and flips that cell and
// its four orthogonal neighbours. Moves counts accepted presses (saturating),
// and Won goes high once the board is cleared.
// Optional macro TORUS_EN: neighbours wrap around the board edges (torus).
// When it is undefined, neighbours that fall off the board are dropped.
module lights_board (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Position,
    input  logic        Toggle,
    input  logic        Load,
    input  logic [63:0] Pattern,
    output logic [63:0] Lights,
    output logic [7:0]  Moves,
    output logic        Won
);

    typedef enum logic [1:0] {IDLE, PLAY, WON} state_t;

    state_t      state_q;
    logic [63:0] lights_q, lights_d;
    logic [7:0]  moves_q, moves_d;
    logic        won_q;
    logic        toggle_q;
    logic        press;
    logic [63:0] mask;

    logic [2:0]  row, col, row_m, row_p, col_m, col_p;

    assign press = Toggle & ~toggle_q;

    // Build the flip mask for the pressed cell and its in-row/in-column neighbours
    always_comb begin
        row   = Position[5:3];
        col   = Position[2:0];
        row_m = row - 3'd1;
        row_p = row + 3'd1;
        col_m = col - 3'd1;
        col_p = col + 3'd1;
        mask  = '0;
        mask[{row, col}] = 1'b1;
`ifdef TORUS_EN
        // 3-bit arithmetic wraps naturally; columns stay within the same row
        mask[{row_m, col}] = 1'b1;
        mask[{row_p, col}] = 1'b1;
        mask[{row, col_m}] = 1'b1;
        mask[{row, col_p}] = 1'b1;
`else
        // Off-board neighbours are dropped so edges never alias to other rows
        if (row != 3'd0) mask[{row_m, col}] = 1'b1;
        if (row != 3'd7) mask[{row_p, col}] = 1'b1;
        if (col != 3'd0) mask[{row, col_m}] = 1'b1;
        if (col != 3'd7) mask[{row, col_p}] = 1'b1;
`endif
    end

    // Post-press board and saturating move count
    always_comb begin
        lights_d = lights_q ^ mask;
        moves_d  = (moves_q == 8'd255) ? moves_q : moves_q + 8'd1;
    end

    // Game FSM: Load beats a press on the same edge; presses only count in PLAY
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lights_q <= '0;
            moves_q  <= '0;
            won_q    <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= Toggle;
            if (Load) begin
                lights_q <= Pattern;
                moves_q  <= '0;
                if (Pattern == 64'd0) begin
                    state_q <= WON;
                    won_q   <= 1'b1;
                end else begin
                    state_q <= PLAY;
                    won_q   <= 1'b0;
                end
            end else if (press && state_q == PLAY) begin
                lights_q <= lights_d;
                moves_q  <= moves_d;
                if (lights_d == 64'd0) begin
                    state_q <= WON;
                    won_q   <= 1'b1;
                end
            end
        end
    end

    assign Lights = lights_q;
    assign Moves  = moves_q;
    assign Won    = won_q;

endmodule
